// File: rtl/qam_pkg.sv
// Shared widths, sample/LO/product types and saturating negation for the QAM down-mixer.
package qam_pkg;

    localparam int unsigned QAM_DIN_W = 10;
    localparam int unsigned QAM_LO_W  = 8;
    localparam int unsigned QAM_OUT_W = 18;

    typedef logic signed [QAM_DIN_W-1:0]          sample_t;
    typedef logic signed [QAM_LO_W-1:0]           lo_t;
    typedef logic signed [QAM_DIN_W+QAM_LO_W-1:0] prod_t;

    // Negate a w-bit value carried in 32 bits; the most negative code maps to the most positive.
    function automatic logic signed [31:0] sat_neg(input logic signed [31:0] v,
                                                   input int unsigned w);
        logic signed [31:0] lo_min;
        lo_min = -(32'sd1 <<< (w - 1));
        if (v == lo_min) begin
            return ~lo_min;
        end
        return -v;
    endfunction

endpackage

// File: rtl/qam_sync_fifo.sv
// Synchronous FIFO with registered read data, occupancy level and per-cycle ovf/udf pulses.
module qam_sync_fifo #(
    parameter int unsigned Width = 10,
    parameter int unsigned Depth = 32
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     flush_i,
    input  logic                     push_i,
    input  logic [Width-1:0]         wdata_i,
    input  logic                     pop_i,
    output logic [Width-1:0]         rdata_o,
    output logic                     pop_ok_o,
    output logic [$clog2(Depth):0]   level_o,
    output logic                     ovf_o,
    output logic                     udf_o
);

    localparam int unsigned AW = $clog2(Depth);
    localparam int unsigned LW = AW + 1;

    logic [Width-1:0] mem_q [Depth];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]    level_q, level_d;
    logic [Width-1:0] rdata_q;
    logic             full, empty, do_push, do_pop;

    assign full  = (level_q == LW'(Depth));
    assign empty = (level_q == '0);

    // A pop on a full FIFO frees the slot the same-cycle push lands in.
    assign do_pop  = pop_i && !empty && !flush_i;
    assign do_push = push_i && (!full || do_pop) && !flush_i;

    assign ovf_o    = push_i && !flush_i && !do_push;
    assign udf_o    = pop_i && !flush_i && empty;
    assign pop_ok_o = do_pop;
    assign rdata_o  = rdata_q;
    assign level_o  = level_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
            level_d = level_q + LW'(do_push) - LW'(do_pop);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            rdata_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            if (do_pop) rdata_q <= mem_q[rd_ptr_q];
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata_i;
    end

endmodule

// File: rtl/qam_demult_mc.sv
// QAM down-mixer: buffers samples, multiplies by cos and -sin through a MULT_LAT pipeline.
// Optional flush input enabled by defining QAM_DEMULT_FLUSH_EN.
module qam_demult_mc
    import qam_pkg::*;
#(
    parameter int unsigned DIN_W      = QAM_DIN_W,
    parameter int unsigned LO_W       = QAM_LO_W,
    parameter int unsigned OUT_W      = QAM_OUT_W,
    parameter int unsigned FIFO_DEPTH = 32,
    parameter int unsigned MULT_LAT   = 4
) (
    input  logic                            axi_clk,
    input  logic                            axi_rstn,
`ifdef QAM_DEMULT_FLUSH_EN
    input  logic                            flush,
`endif
    input  logic                            qam_valid,
    input  logic signed [DIN_W-1:0]         qam_in,
    input  logic                            cor_valid,
    input  logic signed [LO_W-1:0]          sin,
    input  logic signed [LO_W-1:0]          cos,
    output logic                            demult_valid,
    output logic signed [OUT_W-1:0]         demult_i,
    output logic signed [OUT_W-1:0]         demult_q,
    output logic [$clog2(FIFO_DEPTH):0]     fifo_level,
    output logic                            fifo_ovf,
    output logic                            fifo_udf
);

    localparam int unsigned PROD_W = DIN_W + LO_W;

    logic flush_w;
`ifdef QAM_DEMULT_FLUSH_EN
    assign flush_w = flush;
`else
    assign flush_w = 1'b0;
`endif

    logic [DIN_W-1:0] fifo_rdata;
    logic             fifo_pop_ok, fifo_ovf_p, fifo_udf_p;

    qam_sync_fifo #(
        .Width (DIN_W),
        .Depth (FIFO_DEPTH)
    ) u_fifo (
        .clk_i    (axi_clk),
        .rst_ni   (axi_rstn),
        .flush_i  (flush_w),
        .push_i   (qam_valid),
        .wdata_i  (qam_in),
        .pop_i    (cor_valid),
        .rdata_o  (fifo_rdata),
        .pop_ok_o (fifo_pop_ok),
        .level_o  (fifo_level),
        .ovf_o    (fifo_ovf_p),
        .udf_o    (fifo_udf_p)
    );

    // Stage 0: the FIFO read register holds the sample; the phase is captured alongside it.
    logic                     v0_q;
    logic signed [LO_W-1:0]   cos_q;
    logic signed [LO_W-1:0]   nsin_q, nsin_d;
    logic signed [DIN_W-1:0]  x_s;
    logic signed [PROD_W-1:0] prod_i, prod_q;

    assign nsin_d = LO_W'(sat_neg(32'(sin), LO_W));
    assign x_s    = $signed(fifo_rdata);

    always_comb begin
        prod_i = PROD_W'(x_s) * PROD_W'(cos_q);
        prod_q = PROD_W'(x_s) * PROD_W'(nsin_q);
    end

    logic signed [OUT_W-1:0] pi_q [MULT_LAT];
    logic signed [OUT_W-1:0] pq_q [MULT_LAT];
    logic [MULT_LAT-1:0]     pv_q;
    logic                    ovf_q, ovf_d, udf_q, udf_d;

    assign ovf_d = ovf_q | fifo_ovf_p;
    assign udf_d = udf_q | fifo_udf_p;

    always_ff @(posedge axi_clk) begin
        if (!axi_rstn) begin
            v0_q   <= 1'b0;
            cos_q  <= '0;
            nsin_q <= '0;
            pv_q   <= '0;
            ovf_q  <= 1'b0;
            udf_q  <= 1'b0;
            for (int k = 0; k < MULT_LAT; k++) begin
                pi_q[k] <= '0;
                pq_q[k] <= '0;
            end
        end else begin
            ovf_q <= ovf_d;
            udf_q <= udf_d;
            v0_q  <= fifo_pop_ok;
            if (fifo_pop_ok) begin
                cos_q  <= cos;
                nsin_q <= nsin_d;
            end
            pv_q[0] <= v0_q;
            if (v0_q) begin
                pi_q[0] <= OUT_W'(prod_i);
                pq_q[0] <= OUT_W'(prod_q);
            end
            // Each stage only loads on a valid slot so the last stage holds between strobes.
            for (int k = 1; k < MULT_LAT; k++) begin
                pv_q[k] <= pv_q[k-1];
                if (pv_q[k-1]) begin
                    pi_q[k] <= pi_q[k-1];
                    pq_q[k] <= pq_q[k-1];
                end
            end
        end
    end

    assign demult_valid = pv_q[MULT_LAT-1];
    assign demult_i     = pi_q[MULT_LAT-1];
    assign demult_q     = pq_q[MULT_LAT-1];
    assign fifo_ovf     = ovf_q;
    assign fifo_udf     = udf_q;

endmodule
